// File: rtl/conv_pix_streamer_pkg.sv
// Shared types and constants for the conv-unit pixel window streamer.
// Window dimensions below MIN_WIN_DIM are clamped up at launch.
package conv_pix_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MIN_WIN_DIM = 3;
  localparam int MAX_WIN_DIM = 15;

  function automatic logic [3:0] clamp_dim(input logic [3:0] d);
    return (d < 4'(MIN_WIN_DIM)) ? 4'(MIN_WIN_DIM) : d;
  endfunction

  // Largest window is 15x15 = 225, so an 8-bit product never overflows.
  function automatic logic [7:0] win_pixels(input logic [3:0] n);
    return 8'(n) * 8'(n);
  endfunction

endpackage

// File: rtl/conv_pix_streamer_AddrGen.sv
// Incremental row-major window address generator: row base plus column,
// stepping the row base by the stride instead of multiplying.
module conv_pix_streamer_AddrGen #(
  parameter int addr_width = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  advance,
  input  logic [addr_width-1:0] base_addr,
  input  logic [addr_width-1:0] row_stride,
  input  logic [3:0]            dim,
  output logic [addr_width-1:0] addr,
  output logic                  last
);

  logic [addr_width-1:0] row_addr;
  logic [3:0]            col;
  logic [3:0]            row;
  logic                  last_col;

  assign last_col = (col == dim - 4'd1);
  assign last     = last_col && (row == dim - 4'd1);
  assign addr     = row_addr + {{(addr_width-4){1'b0}}, col};

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_addr <= '0;
      col      <= '0;
      row      <= '0;
    end else if (load) begin
      row_addr <= base_addr;
      col      <= '0;
      row      <= '0;
    end else if (advance) begin
      if (last_col) begin
        col      <= '0;
        row      <= row + 4'd1;
        row_addr <= row_addr + row_stride;
      end else begin
        col <= col + 4'd1;
      end
    end
  end

endmodule

// File: rtl/conv_pix_streamer.sv
// Fetches an n x n pixel window from a valid/ready memory and pushes each
// returned pixel, registered, into the conv unit's push-only input.
module conv_pix_streamer
  import conv_pix_streamer_pkg::*;
#(
  parameter int data_width      = 8,
  parameter int addr_width      = 16,
  parameter int max_outstanding = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            win_dim,
  input  logic [addr_width-1:0] base_addr,
  input  logic [addr_width-1:0] row_stride,
  output logic                  mem_req_val,
  input  logic                  mem_req_rdy,
  output logic [addr_width-1:0] mem_req_addr,
  input  logic                  mem_resp_val,
  input  logic [data_width-1:0] mem_resp_data,
  output logic [data_width-1:0] pix,
  output logic                  pix_val,
  output logic                  busy,
  output logic                  done
);

  state_t                state;
  state_t                state_next;
  logic [3:0]            dim_q;
  logic [addr_width-1:0] stride_q;
  logic [7:0]            total_q;
  logic [2:0]            outstanding;
  logic [7:0]            resp_count;
  logic                  accept_start;
  logic                  in_window;
  logic                  fire;
  logic                  resp_acc;
  logic                  resp_dec;
  logic                  last_pix;

  assign accept_start = (state == IDLE) && start;
  assign in_window    = (state == FETCH) || (state == DRAIN);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign mem_req_val  = (state == FETCH) && (outstanding < 3'(max_outstanding));
  assign fire         = mem_req_val && mem_req_rdy;
  assign resp_acc     = mem_resp_val && in_window;
  assign resp_dec     = mem_resp_val && busy;

  conv_pix_streamer_AddrGen #(
    .addr_width (addr_width)
  ) addr_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (accept_start),
    .advance    (fire),
    .base_addr  (base_addr),
    .row_stride (stride_q),
    .dim        (dim_q),
    .addr       (mem_req_addr),
    .last       (last_pix)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // The memory has at least one cycle of latency, so the final response
  // always lands in DRAIN, never in FETCH.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_start) state_next = FETCH;
      FETCH:   if (fire && last_pix) state_next = DRAIN;
      DRAIN:   if (resp_acc && (resp_count == total_q - 8'd1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dim_q    <= '0;
      stride_q <= '0;
      total_q  <= '0;
    end else if (accept_start) begin
      dim_q    <= clamp_dim(win_dim);
      stride_q <= row_stride;
      total_q  <= win_pixels(clamp_dim(win_dim));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      outstanding <= '0;
      resp_count  <= '0;
    end else if (accept_start) begin
      outstanding <= '0;
      resp_count  <= '0;
    end else begin
      outstanding <= outstanding + {2'b00, fire} - {2'b00, resp_dec};
      resp_count  <= resp_count + {7'd0, resp_acc};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pix     <= '0;
      pix_val <= 1'b0;
    end else begin
      pix_val <= resp_acc;
      if (resp_acc) pix <= mem_resp_data;
    end
  end

endmodule

// File: tb/tb_conv_pix_streamer.sv
// Directed bench for conv_pix_streamer: a latency-configurable in-order
// memory model plus a negedge monitor recording requests and pixels.
module tb_conv_pix_streamer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  win_dim = 4'd0;
  logic [15:0] base_addr = 16'd0;
  logic [15:0] row_stride = 16'd0;
  logic        mem_req_rdy = 1'b1;
  logic        mem_req_val;
  logic [15:0] mem_req_addr;
  logic        mem_resp_val;
  logic [7:0]  mem_resp_data;
  logic [7:0]  pix;
  logic        pix_val;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  conv_pix_streamer #(
    .data_width      (8),
    .addr_width      (16),
    .max_outstanding (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .win_dim       (win_dim),
    .base_addr     (base_addr),
    .row_stride    (row_stride),
    .mem_req_val   (mem_req_val),
    .mem_req_rdy   (mem_req_rdy),
    .mem_req_addr  (mem_req_addr),
    .mem_resp_val  (mem_resp_val),
    .mem_resp_data (mem_resp_data),
    .pix           (pix),
    .pix_val       (pix_val),
    .busy          (busy),
    .done          (done)
  );

  int assert_count = 0;
  int fail_count = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_data(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Memory model: fixed latency of lat_idx+1 cycles, responses never stall.
  logic [1:0] lat_idx = 2'd0;
  logic [3:0] pv = 4'd0;
  logic [7:0] pd [4];

  always @(posedge clk) begin
    pv    <= {pv[2:0], mem_req_val && mem_req_rdy};
    pd[0] <= mem_data(mem_req_addr);
    pd[1] <= pd[0];
    pd[2] <= pd[1];
    pd[3] <= pd[2];
  end

  assign mem_resp_val  = pv[lat_idx];
  assign mem_resp_data = pd[lat_idx];

  logic [15:0] req_q [$];
  logic [7:0]  pix_q [$];
  int          done_count = 0;
  int          stall_viol = 0;
  int          flight_viol = 0;
  int          issued = 0;
  int          answered = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_addr = 16'd0;

  always @(negedge clk) begin
    if (prev_stall && mem_req_val && (mem_req_addr !== prev_addr)) stall_viol++;
    if (mem_req_val && mem_req_rdy) begin
      if (issued - answered >= 2) flight_viol++;
      req_q.push_back(mem_req_addr);
      issued++;
    end
    if (mem_resp_val) answered++;
    if (pix_val) pix_q.push_back(pix);
    if (done) done_count++;
    prev_stall = mem_req_val && !mem_req_rdy;
    prev_addr  = mem_req_addr;
  end

  // Entered and left at posedge+1; a following call launches back-to-back.
  task automatic applyStimulus(input logic [3:0] d, input logic [15:0] b, input logic [15:0] s,
                               input int lat, input int mode, input bit repulse);
    int n, q0, p0, d0, sv0, fv0;
    bit seen;
    logic [15:0] exp_addr;
    n = (d < 4'd3) ? 3 : int'(d);
    lat_idx = 2'(lat - 1);
    win_dim = d;
    base_addr = b;
    row_stride = s;
    mem_req_rdy = 1'b1;
    q0 = req_q.size();
    p0 = pix_q.size();
    d0 = done_count;
    sv0 = stall_viol;
    fv0 = flight_viol;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_rise", 32'(busy), 32'd1);
    checkOutput("req_val_rise", 32'(mem_req_val), 32'd1);
    checkOutput("first_addr", 32'(mem_req_addr), 32'(b));
    seen = 1'b0;
    for (int cyc = 0; cyc < 2000 && !seen; cyc++) begin
      if (done) begin
        seen = 1'b1;
        checkOutput("done_with_pix_val", 32'(pix_val), 32'd1);
      end else begin
        if (mode == 1) mem_req_rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        if (repulse && cyc == 2) begin
          start = 1'b1;
          win_dim = 4'd5;
          base_addr = 16'h0777;
          row_stride = 16'd1;
        end
        if (repulse && cyc == 3) start = 1'b0;
        @(posedge clk); #1;
      end
    end
    checkOutput("done_seen", 32'(seen), 32'd1);
    mem_req_rdy = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("busy_fall", 32'(busy), 32'd0);
    checkOutput("done_fall", 32'(done), 32'd0);
    checkOutput("req_count", 32'(req_q.size() - q0), 32'(n * n));
    checkOutput("pix_count", 32'(pix_q.size() - p0), 32'(n * n));
    for (int i = 0; i < n * n; i++) begin
      exp_addr = 16'(int'(b) + (i / n) * int'(s) + (i % n));
      if (q0 + i < req_q.size()) checkOutput("req_addr", 32'(req_q[q0 + i]), 32'(exp_addr));
      if (p0 + i < pix_q.size()) checkOutput("pix_data", 32'(pix_q[p0 + i]), 32'(mem_data(exp_addr)));
    end
    checkOutput("done_count", 32'(done_count - d0), 32'd1);
    checkOutput("stall_addr_stable", 32'(stall_viol - sv0), 32'd0);
    checkOutput("max_in_flight", 32'(flight_viol - fv0), 32'd0);
  endtask

  initial begin
    int q0, p0, d0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_pix", 32'(pix), 32'd0);
    checkOutput("rst_pix_val", 32'(pix_val), 32'd0);
    checkOutput("rst_req_val", 32'(mem_req_val), 32'd0);
    checkOutput("rst_req_addr", 32'(mem_req_addr), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    applyStimulus(4'd3, 16'h0100, 16'd3, 1, 0, 1'b0);
    applyStimulus(4'd4, 16'h0000, 16'd8, 1, 0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    applyStimulus(4'd3, 16'h0200, 16'd16, 3, 1, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    applyStimulus(4'd1, 16'hFFFE, 16'h0010, 2, 0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    applyStimulus(4'd15, 16'h1000, 16'd32, 1, 0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end

    lat_idx = 2'd2;
    win_dim = 4'd4;
    base_addr = 16'h0040;
    row_stride = 16'd4;
    q0 = req_q.size();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 200 && (req_q.size() - q0) < 16; cyc++) begin
      @(posedge clk); #1;
    end
    checkOutput("drain_reached", 32'(req_q.size() - q0), 32'd16);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid_rst_pix", 32'(pix), 32'd0);
    checkOutput("mid_rst_pix_val", 32'(pix_val), 32'd0);
    checkOutput("mid_rst_req_val", 32'(mem_req_val), 32'd0);
    checkOutput("mid_rst_req_addr", 32'(mem_req_addr), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    p0 = pix_q.size();
    d0 = done_count;
    repeat (6) begin @(posedge clk); #1; end
    checkOutput("late_resp_no_pix", 32'(pix_q.size() - p0), 32'd0);
    checkOutput("late_resp_no_done", 32'(done_count - d0), 32'd0);
    checkOutput("late_resp_idle", 32'(busy), 32'd0);

    applyStimulus(4'd0, 16'h0020, 16'd3, 1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
